// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial line of the UART transmitter.
// master = word producer, slave = uart_tx.
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [4:0]            Prescale;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, Prescale,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Each bit lasts Prescale clocks (0 treated as 1); all outputs registered.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic       CLK,
  input  logic       RST,
  uart_tx_if.slave   bus
);
  localparam int IDX_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] sh_next;
  logic                  par_en_q;
  logic                  par_bit;
  logic [4:0]            period;
  logic [4:0]            cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic                  tx_q;
  logic                  busy_q;
  logic                  bit_tick;

  assign bit_tick   = (cnt == period - 5'd1);
  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

  // The word is shifted right so the bit on the line is always shreg[0],
  // equivalent to indexing the latched word with bit_idx.
  always_comb begin
    sh_next = shreg >> 1;
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      shreg    <= '0;
      par_en_q <= 1'b0;
      par_bit  <= 1'b0;
      period   <= '0;
      cnt      <= '0;
      bit_idx  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.DATA_VALID) begin
        shreg    <= bus.P_DATA;
        par_en_q <= bus.PAR_EN;
        par_bit  <= (^bus.P_DATA) ^ bus.PAR_TYP;
        period   <= (bus.Prescale == 5'd0) ? 5'd1 : bus.Prescale;
        cnt      <= '0;
        bit_idx  <= '0;
        tx_q     <= 1'b0;
        busy_q   <= 1'b1;
        state    <= START;
      end
    end else if (!bit_tick) begin
      cnt <= cnt + 5'd1;
    end else begin
      cnt <= '0;
      case (state)
        START: begin
          state <= DATA;
          tx_q  <= shreg[0];
        end
        DATA: begin
          if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
            bit_idx <= '0;
            if (par_en_q) begin
              state <= PARITY;
              tx_q  <= par_bit;
            end else begin
              state <= STOP;
              tx_q  <= 1'b1;
            end
          end else begin
            bit_idx <= bit_idx + IDX_W'(1);
            shreg   <= sh_next;
            tx_q    <= sh_next[0];
          end
        end
        PARITY: begin
          state <= STOP;
          tx_q  <= 1'b1;
        end
        STOP: begin
          state  <= IDLE;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: per-cycle comparison of TX_OUT/Busy against a
// frame-waveform queue model, plus frame-length and inter-frame gap checks.
module tb_uart_tx;
  localparam int DW = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  uart_tx_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx #(.DATA_WIDTH(DW)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: expected line level for every future cycle of the frame.
  logic   line_q[$];
  logic   m_tx;
  logic   m_busy;
  int     exp_len;
  int     busy_run;
  int     idle_run;
  bit     len_valid;
  bit     gap_check;
  bit     accepted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void build_frame(input logic [DW-1:0] d, input logic pe,
                                      input logic pt, input logic [4:0] ps);
    int   p;
    logic bits[$];
    p = (ps == 0) ? 1 : int'(ps);
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) begin
      int ones = 0;
      for (int i = 0; i < DW; i++) ones += int'(d[i]);
      bits.push_back(pt ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1));
    end
    bits.push_back(1'b1);
    foreach (bits[b]) for (int k = 0; k < p; k++) line_q.push_back(bits[b]);
    exp_len = p * bits.size();
  endfunction

  // One clock: model reacts to the inputs present at the edge, then DUT is checked #1 later.
  task automatic step();
    bit rising;
    accepted = 1'b0;
    if (!rst_n) begin
      line_q.delete();
      len_valid = 1'b0;
    end else if (!m_busy && bus.DATA_VALID) begin
      build_frame(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP, bus.Prescale);
      accepted  = 1'b1;
      len_valid = 1'b1;
    end
    if (line_q.size() > 0) begin
      m_tx   = line_q.pop_front();
      m_busy = 1'b1;
    end else begin
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end
    @(posedge clk);
    #1;
    check("tx_out", {31'b0, bus.TX_OUT}, {31'b0, m_tx});
    check("busy",   {31'b0, bus.Busy},   {31'b0, m_busy});
    rising = (bus.Busy === 1'b1) && (busy_run == 0);
    if (rising && gap_check) begin
      check("gap", idle_run, 1);
      gap_check = 1'b0;
    end
    if (bus.Busy === 1'b1) begin
      busy_run++;
      idle_run = 0;
    end else begin
      if (busy_run > 0 && len_valid && rst_n) check("busy_len", busy_run, exp_len);
      if (!rst_n) busy_run = 0;
      busy_run = 0;
      idle_run++;
    end
    if (!rst_n) busy_run = 0;
  endtask

  task automatic scramble_inputs();
    bus.P_DATA   = DW'($urandom);
    bus.PAR_EN   = 1'($urandom);
    bus.PAR_TYP  = 1'($urandom);
    bus.Prescale = 5'($urandom);
  endtask

  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt, input logic [4:0] ps);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Prescale   = ps;
    bus.DATA_VALID = 1'b1;
    step();
    bus.DATA_VALID = 1'b0;
    scramble_inputs();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((bus.Busy !== 1'b0 || m_busy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check("wait_idle_timeout", 1, 0);
    step();
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    m_tx           = 1'b1;
    m_busy         = 1'b0;
    exp_len        = 0;
    busy_run       = 0;
    idle_run       = 0;
    len_valid      = 1'b0;
    gap_check      = 1'b0;
    rst_n          = 1'b0;
    bus.DATA_VALID = 1'b0;
    scramble_inputs();

    // Reset then idle
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();

    // Basic frame and parity frames from the plan
    send(8'hA5, 1'b0, 1'b0, 5'd8);  wait_idle(200);
    send(8'h03, 1'b1, 1'b0, 5'd16); wait_idle(400);
    send(8'h07, 1'b1, 1'b1, 5'd4);  wait_idle(100);
    send(8'h06, 1'b1, 1'b1, 5'd4);  wait_idle(100);

    // Ignored mid-frame request, then a held request accepted after one idle cycle
    send(8'h55, 1'b0, 1'b0, 5'd8);
    repeat (20) step();
    bus.P_DATA = 8'hFF; bus.DATA_VALID = 1'b1; step();
    bus.DATA_VALID = 1'b0;
    repeat (10) begin bus.P_DATA = ~bus.P_DATA; step(); end
    bus.P_DATA = 8'h0F; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.Prescale = 5'd8;
    bus.DATA_VALID = 1'b1;
    gap_check = 1'b1;
    begin
      int n = 0;
      while (!accepted && n < 200) begin step(); n++; end
      if (!accepted) check("accept_timeout", 1, 0);
    end
    bus.DATA_VALID = 1'b0;
    check("gap_seen", {31'b0, gap_check}, 32'd0);
    wait_idle(200);

    // Abort during DATA, then a clean frame, then Prescale=0
    send(8'h3C, 1'b0, 1'b0, 5'd8);
    repeat (30) step();
    rst_n = 1'b0; step();
    rst_n = 1'b1; step();
    send(8'h96, 1'b1, 1'b0, 5'd8);  wait_idle(200);
    send(8'h81, 1'b0, 1'b0, 5'd0);  wait_idle(50);

    // Randomised traffic with requests while busy, changing inputs and rare resets
    for (int c = 0; c < 4000; c++) begin
      scramble_inputs();
      bus.Prescale   = 5'($urandom_range(0, 6));
      bus.DATA_VALID = ($urandom_range(0, 3) == 0);
      rst_n          = ($urandom_range(0, 599) != 0);
      step();
    end
    rst_n = 1'b1;
    bus.DATA_VALID = 1'b0;
    wait_idle(400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
